// File: rtl/inst_fetch.sv
// Instruction fetch/sequencer: loadable program memory, PC, and a FETCH/EXEC cycle
// that drives the datapath OPCODE bus and its once-per-instruction write strobe.
module inst_fetch #(
    parameter int unsigned ADDR_WIDTH  = 8,
    parameter logic [15:0] HALT_OPCODE = 16'hFFFF
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  START,
    input  logic                  STALL,
    input  logic                  LOAD_EN,
    input  logic [ADDR_WIDTH-1:0] LOAD_ADDR,
    input  logic [15:0]           LOAD_DATA,
    output logic [15:0]           OPCODE,
    output logic [ADDR_WIDTH-1:0] PC,
    output logic                  WRITE_PHASE,
    output logic                  BUSY,
    output logic                  HALTED,
    output logic [15:0]           RETIRED
);

    localparam int unsigned Depth = 2 ** ADDR_WIDTH;
    localparam logic [ADDR_WIDTH-1:0] PcOne = 1;

    typedef enum logic [1:0] {StIdle, StFetch, StExec, StHalt} state_e;

    state_e      state_q;
    logic [15:0] mem [Depth];
    logic [15:0] fetch_word;
    logic        load_ok;

    assign fetch_word = mem[PC];
    assign load_ok    = LOAD_EN && (state_q == StIdle || state_q == StHalt);

    // No reset on the array: program contents survive RST.
    always_ff @(posedge CLK) begin
        if (load_ok) begin
            mem[LOAD_ADDR] <= LOAD_DATA;
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q <= StIdle;
            OPCODE  <= 16'h0000;
            PC      <= '0;
            RETIRED <= 16'h0000;
        end else begin
            unique case (state_q)
                StIdle, StHalt: begin
                    if (START) begin
                        state_q <= StFetch;
                        PC      <= '0;
                    end
                end
                StFetch: begin
                    if (!STALL) begin
                        if (fetch_word == HALT_OPCODE) begin
                            state_q <= StHalt;
                            OPCODE  <= 16'h0000;
                        end else begin
                            state_q <= StExec;
                            OPCODE  <= fetch_word;
                        end
                    end
                end
                StExec: begin
                    state_q <= StFetch;
                    PC      <= PC + PcOne;
                    if (RETIRED != 16'hFFFF) begin
                        RETIRED <= RETIRED + 16'd1;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    // Status strobes decode straight from state so RST clears them without an edge.
    always_comb begin
        WRITE_PHASE = (state_q == StExec);
        BUSY        = (state_q == StFetch) || (state_q == StExec);
        HALTED      = (state_q == StHalt);
    end

endmodule
